ravan_reg_target: RTL and testbench
===================================

# ravan_reg_target

Memory-mapped register responder for the RAVAN engine, implementing the target end of the `cs`/`we`/`address`/`write_data`/`read_data`/`error` bus. A bus initiator drives this bus, the same way the key pipeline drives the SHA-256 core. The block holds a 16-word (512-bit) key bank, a control/status pair and a multi-cycle ARX word-mixing engine. It exposes the 512-bit digest as 16 read-only words, so software or a sequencer can load keys, start a mix, poll for completion and read results.

## Interface
- `ROUNDS`, 8, number of mixing rounds (1–255).
- `clk` input 1, single clock, all state on rising edge.
- `reset_n` input 1, reset; asynchronous, active-low.
- `cs` input 1, access select; one access per cycle while high.
- `we` input 1, 1 = write, 0 = read (sampled with `cs`).
- `address` input 8, word address.
- `write_data` input 32, write payload.
- `read_data` output 32, registered read result.
- `error` output 1, registered access-error pulse.

## Operation
- Address map:
  - 0x00 NAME: RO, 0x7261766E.
  - 0x01 VERSION: RO, 0x00010000.
  - 0x08 CTRL: WO, write-1 pulses. Bit0 = init, bit1 = clear. Reads as 0.
  - 0x09 STATUS: RO. Bit0 = ready, bit1 = valid.
  - 0x10–0x1F KEY[0..15]: RW.
  - 0x20–0x2F DIGEST[0..15]: RO.
- Any unmapped address, any write to an RO register, or a KEY write while busy:
  - `error` = 1.
  - The write is dropped.
  - A read in this case returns 0.
- FSM states:
  - IDLE: ready = 1.
    - CTRL.init → LOAD.
  - LOAD: one cycle.
    - w[i] ← KEY[i].
    - r ← 0.
    - → ROUND.
  - ROUND: one round per cycle.
    - w[i] ← rotl32(w[i] ^ w[(i+1) mod 16], 5) + r, with a 32-bit wrap; all 16 words update in parallel from the old values.
    - r increments each round.
    - After round ROUNDS−1: DIGEST[i] ← final word, valid ← 1, → IDLE.
- ready = 1 only in IDLE.
- CTRL.init outside IDLE is ignored, with no error.
- CTRL.clear in IDLE zeroes all DIGEST words and clears valid. It is ignored outside IDLE.
- init and clear both set in one write: clear wins, init is ignored.
- A new init clears valid on the LOAD cycle. Old DIGEST stays readable until it is overwritten at completion.
- KEY reads are always permitted. DIGEST reads while busy return the previous contents.

## Timing
- Reset values:
  - `read_data` = 0, `error` = 0.
  - FSM = IDLE, ready = 1, valid = 0.
  - KEY, DIGEST and w all 0, r = 0.
- Read latency is 1 cycle:
  - A read sampled at edge k drives `read_data` and `error` after edge k.
  - `read_data` holds until the next read. `error` lasts one cycle.
- Writes take effect at the sampling edge. A read of the same register one cycle later returns the new value.
- Mix latency:
  - CTRL.init is sampled at edge E0. LOAD occupies E0→E1.
  - Rounds complete at edges E2..E(ROUNDS+1).
  - STATUS reads 0x3 for any read sampled at or after edge E(ROUNDS+2).
- Back-to-back accesses are accepted every cycle; no wait states.
- Deasserting `reset_n` mid-mix aborts immediately to reset values.

## Configuration
- `RAVAN_FEEDFWD_EN`:
  - Defined: DIGEST[i] = w[i] ^ KEY[i] (feed-forward of the key bank, which is stable during a mix).
  - Undefined: DIGEST[i] = w[i].
  - The address map and timing are identical in both cases.

## Structure
- Package `ravan_reg_pkg` holds:
  - address constants;
  - NAME and VERSION values;
  - CTRL and STATUS bit indices;
  - the FSM state enum;
  - the rotate amount (5).
- Sub-module `ravan_mix_round`: combinational, taking 16 words plus the round index and returning 16 words. It is instantiated once.

## Test plan
- Read 0x00 after reset → next cycle `read_data` = 0x7261766E, `error` = 0. Read 0x09 → 0x00000001.
- All KEY = 0, ROUNDS = 8, write CTRL = 0x1:
  - STATUS reads 0x0 while busy.
  - STATUS reads 0x3 at E10.
  - Every DIGEST word = 0x00000007 (equal in both configurations).
- Write 0x20 and write 0x50 → `error` pulse 1 cycle each, contents unchanged. A read of 0x50 returns 0.
- During a mix, write KEY[3] = 0xDEADBEEF → `error` = 1, KEY[3] unchanged. A repeated CTRL.init is ignored, and completion stays at E(ROUNDS+1).
- After completion, write CTRL = 0x3 → DIGEST all 0, STATUS = 0x1, no mix starts.
- Pull `reset_n` low mid-ROUND for a fraction of a cycle → all registers return to reset values, STATUS = 0x1, DIGEST = 0.

Source files
------------

// File: rtl/ravan_reg_pkg.sv
// ravan_reg_pkg: shared constants, FSM encoding and helpers for the RAVAN
// register target (address map, ID values, CTRL/STATUS bits, rotate amount).
package ravan_reg_pkg;

    localparam int NUM_WORDS = 16;

    // Address map
    localparam logic [7:0] ADDR_NAME        = 8'h00;
    localparam logic [7:0] ADDR_VERSION     = 8'h01;
    localparam logic [7:0] ADDR_CTRL        = 8'h08;
    localparam logic [7:0] ADDR_STATUS      = 8'h09;
    localparam logic [7:0] ADDR_KEY_BASE    = 8'h10;
    localparam logic [7:0] ADDR_DIGEST_BASE = 8'h20;

    // Identification values
    localparam logic [31:0] NAME_VALUE    = 32'h7261766E;
    localparam logic [31:0] VERSION_VALUE = 32'h00010000;

    // CTRL / STATUS bit positions
    localparam int CTRL_INIT_BIT     = 0;
    localparam int CTRL_CLEAR_BIT    = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int STATUS_VALID_BIT  = 1;

    // Left-rotate amount used by each mixing round
    localparam int ROT_AMT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    // 16 x 32-bit word bank, word i at bits [32*i +: 32]
    typedef logic [NUM_WORDS-1:0][31:0] bank_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x);
        return (x << ROT_AMT) | (x >> (32 - ROT_AMT));
    endfunction

endpackage

// File: rtl/ravan_mix_round.sv
// ravan_mix_round: one combinational ARX round over the 16-word state.
// Every output word is computed from the old words only, so all 16 update
// in parallel: w'[i] = rotl32(w[i] ^ w[(i+1) mod 16], 5) + round_idx.
module ravan_mix_round
    import ravan_reg_pkg::*;
(
    input  bank_t      w_in,
    input  logic [7:0] round_idx,
    output bank_t      w_out
);

    logic [3:0] idx;
    logic [3:0] nxt;

    // Parallel ARX update of all words; the 4-bit neighbour index wraps at 16
    always_comb begin
        w_out = '0;
        idx   = '0;
        nxt   = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            idx        = 4'(i);
            nxt        = idx + 4'd1;
            w_out[idx] = rotl32(w_in[idx] ^ w_in[nxt]) + {24'd0, round_idx};
        end
    end

endmodule

// File: rtl/ravan_reg_target.sv
// ravan_reg_target: memory-mapped register target for the RAVAN engine.
// Holds a 16-word key bank, CTRL/STATUS and a multi-cycle ARX mixer whose
// result is exposed as 16 read-only digest words.
// Build option: define RAVAN_FEEDFWD_EN to XOR the key bank into the final
// words when the digest is captured (DIGEST[i] = w[i] ^ KEY[i]).
//
// Bus handshake: there are no wait states. Every cycle with cs high is one
// accepted access (we selects write/read); its read_data/error response
// appears right after the sampling edge. read_data holds until the next
// read, error is a one-cycle pulse.
module ravan_reg_target
    import ravan_reg_pkg::*;
#(
    parameter int ROUNDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        error,
    output logic [1:0]  dbg_state
);

    state_t      state;
    state_t      state_nxt;
    logic        ready;
    logic        valid;
    logic [7:0]  r;
    bank_t       w;
    bank_t       mixed;
    bank_t       final_words;
    bank_t       key_bank;
    bank_t       digest;
    logic        last_round;

    logic [31:0] rd_val;
    logic        acc_err;
    logic        key_wr;
    logic        ctrl_init;
    logic        ctrl_clear;
    logic [3:0]  word_idx;
    logic [31:0] status_word;

    ravan_mix_round u_mix (
        .w_in      (w),
        .round_idx (r),
        .w_out     (mixed)
    );

    assign last_round = (r == 8'(ROUNDS - 1));
    assign word_idx   = address[3:0];

`ifdef RAVAN_FEEDFWD_EN
    assign final_words = mixed ^ key_bank;
`else
    assign final_words = mixed;
`endif

    // Access decode: read mux, error detection, and write strobes
    always_comb begin
        rd_val      = '0;
        acc_err     = 1'b0;
        key_wr      = 1'b0;
        ctrl_init   = 1'b0;
        ctrl_clear  = 1'b0;
        status_word = '0;
        status_word[STATUS_READY_BIT] = ready;
        status_word[STATUS_VALID_BIT] = valid;
        if (cs) begin
            if (address == ADDR_NAME) begin
                if (we) acc_err = 1'b1;
                else    rd_val  = NAME_VALUE;
            end else if (address == ADDR_VERSION) begin
                if (we) acc_err = 1'b1;
                else    rd_val  = VERSION_VALUE;
            end else if (address == ADDR_CTRL) begin
                // Write-only pulses; clear takes priority over init
                if (we) begin
                    ctrl_clear = write_data[CTRL_CLEAR_BIT];
                    ctrl_init  = write_data[CTRL_INIT_BIT] & ~write_data[CTRL_CLEAR_BIT];
                end
            end else if (address == ADDR_STATUS) begin
                if (we) acc_err = 1'b1;
                else    rd_val  = status_word;
            end else if (address[7:4] == ADDR_KEY_BASE[7:4]) begin
                if (we) begin
                    if (!ready) acc_err = 1'b1;
                    else        key_wr  = 1'b1;
                end else begin
                    rd_val = key_bank[word_idx];
                end
            end else if (address[7:4] == ADDR_DIGEST_BASE[7:4]) begin
                if (we) acc_err = 1'b1;
                else    rd_val  = digest[word_idx];
            end else begin
                acc_err = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic; init outside IDLE is simply ignored
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ctrl_init)  state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ROUND;
            ST_ROUND: if (last_round) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready     = (state == ST_IDLE);
        dbg_state = state;
    end

    // Key bank, working words, round counter, digest and valid flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_bank <= '0;
            digest   <= '0;
            w        <= '0;
            r        <= '0;
            valid    <= 1'b0;
        end else begin
            if (key_wr) key_bank[word_idx] <= write_data;
            case (state)
                ST_IDLE: begin
                    if (ctrl_clear) begin
                        digest <= '0;
                        valid  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    w     <= key_bank;
                    r     <= '0;
                    valid <= 1'b0;
                end
                ST_ROUND: begin
                    w <= mixed;
                    r <= r + 8'd1;
                    if (last_round) begin
                        digest <= final_words;
                        valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered bus response: read data held until next read, error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
            error     <= 1'b0;
        end else begin
            error <= acc_err;
            if (cs && !we) read_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_ravan_reg_target.sv
// tb_ravan_reg_target: randomized scoreboard bench for ravan_reg_target.
// A driver issues bus accesses at the falling edge and pushes the expected
// response from a behavioural model; a monitor pops and compares after the
// sampling edge.
module tb_ravan_reg_target;

    localparam int ROUNDS = 8;

    typedef logic [31:0] words_t [16];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        error;
    logic [1:0]  dbg_state;

    ravan_reg_target #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   cyc  = 0;
    logic pend = 1'b0;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        pend <= cs;
    end

    // ---------------- scoreboard state ----------------
    // entry: [33] = is_read, [32] = expected error, [31:0] = expected data
    logic [33:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    words_t m_key;
    words_t m_dig;
    words_t m_res;
    logic   m_valid;
    int     m_start;

    function automatic logic [31:0] ref_rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic void ref_mix(input words_t key, output words_t res);
        words_t cur;
        words_t nxt;
        cur = key;
        for (int rr = 0; rr < ROUNDS; rr++) begin
            for (int i = 0; i < 16; i++)
                nxt[i] = ref_rotl5(cur[i] ^ cur[(i + 1) % 16]) + 32'(rr);
            cur = nxt;
        end
        for (int i = 0; i < 16; i++) begin
`ifdef RAVAN_FEEDFWD_EN
            res[i] = cur[i] ^ key[i];
`else
            res[i] = cur[i];
`endif
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_key[i] = '0;
            m_dig[i] = '0;
        end
        m_valid = 1'b0;
        m_start = -1;
    endtask

    // Bring the mix timeline up to an access sampled at edge k
    task automatic model_advance(input int k);
        if (m_start >= 0) begin
            if (k > m_start + ROUNDS + 1) begin
                m_dig   = m_res;
                m_valid = 1'b1;
                m_start = -1;
            end else if (k > m_start + 1) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic model_access(input bit w, input logic [7:0] a,
                                input logic [31:0] d, input int k);
        logic        err;
        logic [31:0] rd;
        bit          busy;
        model_advance(k);
        busy = (m_start >= 0);
        err  = 1'b0;
        rd   = '0;
        if (a == 8'h00) begin
            if (w) err = 1'b1; else rd = 32'h7261766E;
        end else if (a == 8'h01) begin
            if (w) err = 1'b1; else rd = 32'h00010000;
        end else if (a == 8'h08) begin
            if (w && !busy) begin
                if (d[1]) begin
                    for (int i = 0; i < 16; i++) m_dig[i] = '0;
                    m_valid = 1'b0;
                end else if (d[0]) begin
                    m_start = k;
                    ref_mix(m_key, m_res);
                end
            end
        end else if (a == 8'h09) begin
            if (w) err = 1'b1; else rd = {30'd0, m_valid, !busy};
        end else if (a >= 8'h10 && a <= 8'h1F) begin
            if (w) begin
                if (busy) err = 1'b1; else m_key[a - 8'h10] = d;
            end else begin
                rd = m_key[a - 8'h10];
            end
        end else if (a >= 8'h20 && a <= 8'h2F) begin
            if (w) err = 1'b1; else rd = m_dig[a - 8'h20];
        end else begin
            err = 1'b1;
        end
        exp_q.push_back({!w, err, rd});
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs         = 1'b1;
        we         = w;
        address    = a;
        write_data = d;
        model_access(w, a, d, cyc + 1);
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cs = 1'b0;
            we = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (read_data !== 32'd0) begin
            n_fail++;
            $display("FAIL %s read_data actual=%08h required=00000000", tag, read_data);
        end
        n_vec++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s error actual=%0b required=0", tag, error);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        model_reset();
        check_reset_outputs("reset_outputs_mid_mix");
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_response addr=%02h actual=%08h required=none",
                         address, read_data);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (error !== e[32]) begin
                    n_fail++;
                    $display("FAIL error_flag cyc=%0d actual=%0b required=%0b",
                             cyc, error, e[32]);
                end
                if (e[33]) begin
                    n_vec++;
                    if (read_data !== e[31:0]) begin
                        n_fail++;
                        $display("FAIL read_data cyc=%0d actual=%08h required=%08h",
                                 cyc, read_data, e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        bit          w;
        cs         = 1'b0;
        we         = 1'b0;
        address    = '0;
        write_data = '0;
        reset_n    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("reset_outputs");

        // ID registers and idle status
        bus(0, 8'h00, '0);
        bus(0, 8'h01, '0);
        bus(0, 8'h09, '0);
        bus(0, 8'h08, '0);

        // All-zero key mix, poll status through completion, read digest
        bus(1, 8'h08, 32'h1);
        repeat (ROUNDS + 4) bus(0, 8'h09, '0);
        for (int i = 0; i < 16; i++) bus(0, 8'(8'h20 + i), '0);

        // Illegal writes and unmapped reads
        bus(1, 8'h20, 32'h12345678);
        bus(1, 8'h50, 32'h12345678);
        bus(0, 8'h50, '0);
        bus(0, 8'h20, '0);
        bus(1, 8'h09, 32'hFFFFFFFF);
        bus(1, 8'h00, 32'hFFFFFFFF);

        // Random keys; key write and repeated init while busy
        for (int i = 0; i < 16; i++) bus(1, 8'(8'h10 + i), $urandom());
        bus(1, 8'h08, 32'h1);
        bus(1, 8'h13, 32'hDEADBEEF);
        bus(1, 8'h08, 32'h1);
        bus(0, 8'h13, '0);
        for (int i = 0; i < 16; i++) bus(0, 8'(8'h20 + i), '0);
        repeat (ROUNDS) bus(0, 8'h09, '0);
        for (int i = 0; i < 16; i++) bus(0, 8'(8'h20 + i), '0);

        // Clear wins over init
        bus(1, 8'h08, 32'h3);
        bus(0, 8'h09, '0);
        bus(0, 8'h21, '0);
        bus(0, 8'h2F, '0);
        bus_idle(3);
        bus(0, 8'h09, '0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h08;
                3: a = 8'h09;
                4: a = 8'(8'h10 + $urandom_range(0, 15));
                5: a = 8'(8'h20 + $urandom_range(0, 15));
                6: a = 8'(8'h10 + $urandom_range(0, 15));
                default: a = 8'($urandom_range(0, 255));
            endcase
            w = ($urandom_range(0, 1) == 1);
            d = (a == 8'h08) ? 32'($urandom_range(0, 3)) : $urandom();
            if ($urandom_range(0, 9) == 0) bus_idle(1);
            else                           bus(w, a, d);
        end

        // Reset pulse in the middle of a mix
        bus_idle(ROUNDS + 4);
        bus(1, 8'h11, 32'hCAFEF00D);
        bus(1, 8'h08, 32'h1);
        bus_idle(4);
        pulse_reset();
        bus(0, 8'h09, '0);
        bus(0, 8'h11, '0);
        for (int i = 0; i < 16; i++) bus(0, 8'(8'h20 + i), '0);
        bus(0, 8'h09, '0);
        bus_idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_queue actual=%0d pending required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
